// File: rtl/alarm_timer_fsm.sv
// ---------------------------------------------------------------------------
// alarm_timer_fsm
//
// Purpose:
//   Second-tick alarm timer. Counts up (0 -> max) or down (max -> 0) toward a
//   target latched at start, then raises an alarm. Supports pause/resume,
//   synchronous clear, acknowledge, bounded alarm hold with auto-clear and
//   auto-repeat. All outputs are registered.
//
// Optional feature macro:
//   ALARM_SNOOZE_EN - adds the snooze input and a SNOOZE state that silences
//                     the alarm for SNOOZE cycles before re-alarming.
//
// Parameters:
//   SIZE       - width of max and count in bits
//   ALARM_HOLD - cycles the alarm stays high without ack (0 = until ack)
//   SNOOZE     - snooze length in cycles (ALARM_SNOOZE_EN builds only)
//
// Ports:
//   sec_clk     in   one-second clock, all logic on its rising edge
//   rst_n       in   synchronous reset, active-low
//   enable      in   1 = start/run, 0 = pause (also gates auto-repeat)
//   clear       in   synchronous abort to IDLE
//   mode        in   0 = count up, 1 = count down (sampled at start)
//   max         in   target value (sampled at start)
//   repeat_mode in   auto-restart after alarm (sampled at start)
//   ack         in   acknowledge / clear alarm
//   snooze      in   snooze request in ALARM (ALARM_SNOOZE_EN only)
//   count       out  current count
//   alarm       out  alarm active
//   running     out  high while in RUN
//   done        out  one-cycle pulse on the edge entering ALARM
// ---------------------------------------------------------------------------
module alarm_timer_fsm #(
  parameter int SIZE       = 4,
  parameter int ALARM_HOLD = 3,
  parameter int SNOOZE     = 3
) (
  input  logic            sec_clk,
  input  logic            rst_n,
  input  logic            enable,
  input  logic            clear,
  input  logic            mode,
  input  logic [SIZE-1:0] max,
  input  logic            repeat_mode,
  input  logic            ack,
`ifdef ALARM_SNOOZE_EN
  input  logic            snooze,
`endif
  output logic [SIZE-1:0] count,
  output logic            alarm,
  output logic            running,
  output logic            done
);

  // Hold timer is kept at least one bit wide so ALARM_HOLD=0 still elaborates.
  localparam int HOLD_W = (ALARM_HOLD > 0) ? $clog2(ALARM_HOLD + 1) : 1;
  localparam bit HOLD_EN = (ALARM_HOLD > 0);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((ALARM_HOLD > 0) ? (ALARM_HOLD - 1) : 0);
  localparam logic [HOLD_W-1:0] HOLD_SAT  = {HOLD_W{1'b1}};
  localparam logic [SIZE-1:0]   CNT_ZERO  = {SIZE{1'b0}};
  localparam logic [SIZE-1:0]   CNT_ONE   = SIZE'(1);

`ifdef ALARM_SNOOZE_EN
  localparam int SNZ_W = (SNOOZE > 0) ? $clog2(SNOOZE + 1) : 1;
  localparam logic [SNZ_W-1:0] SNZ_LAST = SNZ_W'((SNOOZE > 0) ? (SNOOZE - 1) : 0);
  localparam logic [SNZ_W-1:0] SNZ_SAT  = {SNZ_W{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RUN    = 3'd1,
    S_PAUSE  = 3'd2,
    S_ALARM  = 3'd3,
    S_SNOOZE = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RUN    = 3'd1,
    S_PAUSE  = 3'd2,
    S_ALARM  = 3'd3
  } state_t;
`endif

  // Registers
  state_t            r_state;
  logic [SIZE-1:0]   r_count;
  logic              r_alarm;
  logic              r_running;
  logic              r_done;
  logic [HOLD_W-1:0] r_hold;
  logic [SIZE-1:0]   r_max;
  logic              r_mode;
  logic              r_repeat;
`ifdef ALARM_SNOOZE_EN
  logic [SNZ_W-1:0]  r_snz;
`endif

  // Combinational helpers
  state_t            w_state_nxt;
  logic [SIZE-1:0]   w_count_nxt;
  logic              w_alarm_nxt;
  logic              w_running_nxt;
  logic              w_done_nxt;
  logic [HOLD_W-1:0] w_hold_nxt;
  logic              w_latch;
  logic              w_start;
  logic [SIZE-1:0]   w_target;
  logic [SIZE-1:0]   w_step;
  logic              w_hit;
  logic              w_timeout;
  logic              w_snooze_req;
  logic              w_alarm_exit;
  logic              w_reload;
  logic [SIZE-1:0]   w_start_val;
`ifdef ALARM_SNOOZE_EN
  logic [SNZ_W-1:0]  w_snz_nxt;
`endif

  // A zero target would alarm without counting, so it never starts a run.
  assign w_start     = enable && (max != CNT_ZERO);
  assign w_target    = r_mode ? CNT_ZERO : r_max;
  assign w_step      = r_mode ? (r_count - CNT_ONE) : (r_count + CNT_ONE);
  assign w_hit       = (w_step == w_target);
  assign w_timeout   = HOLD_EN && (r_hold == HOLD_LAST);
  assign w_reload    = r_repeat && enable;
  assign w_start_val = r_mode ? r_max : CNT_ZERO;

`ifdef ALARM_SNOOZE_EN
  // Snooze yields to ack but wins over a timeout landing on the same edge.
  assign w_snooze_req = snooze && !ack;
`else
  assign w_snooze_req = 1'b0;
`endif
  // ack and timeout together still produce one exit.
  assign w_alarm_exit = ack || (w_timeout && !w_snooze_req);

  assign count   = r_count;
  assign alarm   = r_alarm;
  assign running = r_running;
  assign done    = r_done;

  // State register with synchronous active-low reset.
  always_ff @(posedge sec_clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode; clear overrides every state.
  always_comb begin
    w_state_nxt = r_state;
    if (clear) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            w_state_nxt = S_RUN;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
        S_RUN: begin
          if (!enable) begin
            w_state_nxt = S_PAUSE;
          end else if (w_hit) begin
            w_state_nxt = S_ALARM;
          end else begin
            w_state_nxt = S_RUN;
          end
        end
        S_PAUSE: begin
          if (enable) begin
            w_state_nxt = S_RUN;
          end else begin
            w_state_nxt = S_PAUSE;
          end
        end
        S_ALARM: begin
          if (w_alarm_exit) begin
            if (w_reload) begin
              w_state_nxt = S_RUN;
            end else begin
              w_state_nxt = S_IDLE;
            end
`ifdef ALARM_SNOOZE_EN
          end else if (w_snooze_req) begin
            w_state_nxt = S_SNOOZE;
`endif
          end else begin
            w_state_nxt = S_ALARM;
          end
        end
`ifdef ALARM_SNOOZE_EN
        S_SNOOZE: begin
          if (r_snz == SNZ_LAST) begin
            w_state_nxt = S_ALARM;
          end else begin
            w_state_nxt = S_SNOOZE;
          end
        end
`endif
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  // Next values of the registered outputs and datapath.
  always_comb begin
    w_running_nxt = (w_state_nxt == S_RUN);
    w_alarm_nxt   = (w_state_nxt == S_ALARM);
    // Only a transition into ALARM pulses done (from RUN, or from SNOOZE).
    w_done_nxt    = (w_state_nxt == S_ALARM) && (r_state != S_ALARM);
    w_latch       = 1'b0;
    w_count_nxt   = r_count;

    if (clear) begin
      w_count_nxt = CNT_ZERO;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            w_latch     = 1'b1;
            w_count_nxt = mode ? max : CNT_ZERO;
          end else begin
            w_count_nxt = CNT_ZERO;
          end
        end
        S_RUN: begin
          if (enable) begin
            w_count_nxt = w_step;
          end else begin
            w_count_nxt = r_count;
          end
        end
        S_PAUSE: begin
          w_count_nxt = r_count;
        end
        S_ALARM: begin
          if (w_alarm_exit) begin
            if (w_reload) begin
              w_count_nxt = w_start_val;
            end else begin
              w_count_nxt = CNT_ZERO;
            end
          end else begin
            w_count_nxt = r_count;
          end
        end
`ifdef ALARM_SNOOZE_EN
        S_SNOOZE: begin
          w_count_nxt = r_count;
        end
`endif
        default: begin
          w_count_nxt = CNT_ZERO;
        end
      endcase
    end

    // Hold timer restarts on every entry to ALARM and saturates while held.
    if ((r_state == S_ALARM) && (w_state_nxt == S_ALARM)) begin
      if (r_hold != HOLD_SAT) begin
        w_hold_nxt = r_hold + HOLD_W'(1);
      end else begin
        w_hold_nxt = r_hold;
      end
    end else begin
      w_hold_nxt = {HOLD_W{1'b0}};
    end

`ifdef ALARM_SNOOZE_EN
    if ((r_state == S_SNOOZE) && (w_state_nxt == S_SNOOZE)) begin
      if (r_snz != SNZ_SAT) begin
        w_snz_nxt = r_snz + SNZ_W'(1);
      end else begin
        w_snz_nxt = r_snz;
      end
    end else begin
      w_snz_nxt = {SNZ_W{1'b0}};
    end
`endif
  end

  // Datapath and output registers.
  always_ff @(posedge sec_clk) begin
    if (!rst_n) begin
      r_count   <= CNT_ZERO;
      r_alarm   <= 1'b0;
      r_running <= 1'b0;
      r_done    <= 1'b0;
      r_hold    <= {HOLD_W{1'b0}};
      r_max     <= CNT_ZERO;
      r_mode    <= 1'b0;
      r_repeat  <= 1'b0;
`ifdef ALARM_SNOOZE_EN
      r_snz     <= {SNZ_W{1'b0}};
`endif
    end else begin
      r_count   <= w_count_nxt;
      r_alarm   <= w_alarm_nxt;
      r_running <= w_running_nxt;
      r_done    <= w_done_nxt;
      r_hold    <= w_hold_nxt;
`ifdef ALARM_SNOOZE_EN
      r_snz     <= w_snz_nxt;
`endif
      if (w_latch) begin
        r_max    <= max;
        r_mode   <= mode;
        r_repeat <= repeat_mode;
      end else begin
        r_max    <= r_max;
        r_mode   <= r_mode;
        r_repeat <= r_repeat;
      end
    end
  end

endmodule
